// File: rtl/mlp_pkg.sv
// mlp_pkg: shared types and constants for the MLP accelerator load path.
package mlp_pkg;

  localparam int unsigned LANES         = 16;
  localparam int unsigned DW            = 16;
  localparam int unsigned BEATS_PER_VEC = 8;
  localparam int unsigned CNT_W         = $clog2(BEATS_PER_VEC);
  localparam int unsigned IDX_W         = 4;
  localparam int unsigned LAYER_W       = 3;

  localparam int unsigned ERR_W     = 2;
  localparam int unsigned ERR_OVF   = 0;
  localparam int unsigned ERR_PROTO = 1;

  typedef logic [LANES-1:0][DW-1:0] mlp_vec_t;

  typedef enum logic {
    S_IN,
    S_W
  } mlp_state_e;

  typedef struct packed {
    mlp_vec_t             inp;
    mlp_vec_t             wgt;
    logic [IDX_W-1:0]     idx;
    logic [LAYER_W-1:0]   layer;
  } mlp_grp_t;

  // Write one two-lane beat into lanes 2*slot and 2*slot+1 of a vector.
  function automatic mlp_vec_t put_pair(input mlp_vec_t        v,
                                        input logic [CNT_W-1:0] slot,
                                        input logic [2*DW-1:0]  payload);
    mlp_vec_t r;
    r = v;
    r[{slot, 1'b0}] = payload[DW-1:0];
    r[{slot, 1'b1}] = payload[2*DW-1:DW];
    return r;
  endfunction

endpackage

// File: rtl/mlp_grp_slot.sv
// mlp_grp_slot: single-entry output register for completed groups, with a sticky overflow flag.
module mlp_grp_slot
  import mlp_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load_i,
  input  logic     ready_i,
  input  mlp_grp_t grp_i,
  output logic     valid_o,
  output mlp_grp_t grp_o,
  output logic     ovf_o
);

  logic     valid_q, valid_d;
  logic     ovf_q, ovf_d;
  mlp_grp_t grp_q, grp_d;
  logic     free_c;

  // Load when empty or draining this cycle; otherwise drop the group and flag overflow.
  always_comb begin
    valid_d = valid_q;
    ovf_d   = ovf_q;
    grp_d   = grp_q;
    free_c  = !valid_q || ready_i;
    if (load_i && free_c) begin
      grp_d   = grp_i;
      valid_d = 1'b1;
    end else if (load_i) begin
      ovf_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      grp_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      grp_q   <= grp_d;
    end
  end

  assign valid_o = valid_q;
  assign grp_o   = grp_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/mlp_load_rx.sv
// mlp_load_rx: unpacks host load beats into input-row/weight-column groups for the compute array.
// Define MLP_LOAD_RX_CHECK_EN to enable protocol checks reported on err_o[1].
module mlp_load_rx #(
  parameter int unsigned LANES = mlp_pkg::LANES,
  parameter int unsigned DW    = mlp_pkg::DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en_i,
  input  logic [2*DW-1:0]       load_payload_i,
  input  logic                  load_type_i,
  input  logic [3:0]            input_load_number,
  input  logic [2:0]            layer_number,
  input  logic [2:0]            weight_number,
  output logic                  grp_valid_o,
  input  logic                  grp_ready_i,
  output logic [LANES*DW-1:0]   grp_input_o,
  output logic [LANES*DW-1:0]   grp_weight_o,
  output logic [3:0]            grp_index_o,
  output logic [2:0]            grp_layer_o,
  output logic [1:0]            err_o
);

  import mlp_pkg::mlp_vec_t;
  import mlp_pkg::mlp_grp_t;
  import mlp_pkg::mlp_state_e;
  import mlp_pkg::S_IN;
  import mlp_pkg::S_W;
  import mlp_pkg::CNT_W;
  import mlp_pkg::BEATS_PER_VEC;
  import mlp_pkg::IDX_W;
  import mlp_pkg::LAYER_W;
  import mlp_pkg::ERR_OVF;
  import mlp_pkg::ERR_PROTO;
  import mlp_pkg::put_pair;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mlp_state_e          state_q, state_d;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]    w_cnt_q, w_cnt_d;
  mlp_vec_t            asm_in_q, asm_in_d;
  mlp_vec_t            asm_w_q, asm_w_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LAYER_W-1:0]  layer_q, layer_d;
  logic                proto_q, proto_d;
  logic                proto_err_c;
  logic                complete_c;
  mlp_grp_t            grp_cand_c;
  mlp_grp_t            slot_grp;
  logic                slot_ovf;

  // Protocol checks: wrong-type beat, out-of-order weight slot, or index/layer change mid-group.
  always_comb begin
    proto_err_c = 1'b0;
`ifdef MLP_LOAD_RX_CHECK_EN
    if (load_en_i) begin
      if ((state_q == S_IN) != load_type_i) begin
        proto_err_c = 1'b1;
      end
      if ((state_q == S_W) && (weight_number != w_cnt_q)) begin
        proto_err_c = 1'b1;
      end
      if (((state_q == S_W) || (in_cnt_q != '0)) &&
          ((input_load_number != idx_q) || (layer_number != layer_q))) begin
        proto_err_c = 1'b1;
      end
    end
`endif
  end

  // Beat assembly FSM: eight input beats, then eight weight beats complete a group.
  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    w_cnt_d    = w_cnt_q;
    asm_in_d   = asm_in_q;
    asm_w_d    = asm_w_q;
    idx_d      = idx_q;
    layer_d    = layer_q;
    proto_d    = proto_q;
    complete_c = 1'b0;

    if (proto_err_c) begin
      state_d  = S_IN;
      in_cnt_d = '0;
      w_cnt_d  = '0;
      proto_d  = 1'b1;
    end else begin
      case (state_q)
        S_IN: begin
          if (load_en_i && load_type_i) begin
            asm_in_d = put_pair(asm_in_q, in_cnt_q, load_payload_i);
            if (in_cnt_q == '0) begin
              idx_d   = input_load_number;
              layer_d = layer_number;
            end
            if (in_cnt_q == LAST_BEAT) begin
              in_cnt_d = '0;
              state_d  = S_W;
            end else begin
              in_cnt_d = in_cnt_q + CNT_ONE;
            end
          end
        end
        S_W: begin
          if (load_en_i && !load_type_i) begin
            asm_w_d = put_pair(asm_w_q, weight_number, load_payload_i);
            if (w_cnt_q == LAST_BEAT) begin
              w_cnt_d    = '0;
              state_d    = S_IN;
              complete_c = 1'b1;
            end else begin
              w_cnt_d = w_cnt_q + CNT_ONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IN;
      in_cnt_q <= '0;
      w_cnt_q  <= '0;
      asm_in_q <= '0;
      asm_w_q  <= '0;
      idx_q    <= '0;
      layer_q  <= '0;
      proto_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      w_cnt_q  <= w_cnt_d;
      asm_in_q <= asm_in_d;
      asm_w_q  <= asm_w_d;
      idx_q    <= idx_d;
      layer_q  <= layer_d;
      proto_q  <= proto_d;
    end
  end

  // The final weight beat is folded in directly so the group leaves on its completing edge.
  always_comb begin
    grp_cand_c       = '0;
    grp_cand_c.inp   = asm_in_q;
    grp_cand_c.wgt   = asm_w_d;
    grp_cand_c.idx   = idx_q;
    grp_cand_c.layer = layer_q;
  end

  mlp_grp_slot u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (complete_c),
    .ready_i (grp_ready_i),
    .grp_i   (grp_cand_c),
    .valid_o (grp_valid_o),
    .grp_o   (slot_grp),
    .ovf_o   (slot_ovf)
  );

  assign grp_input_o          = slot_grp.inp;
  assign grp_weight_o         = slot_grp.wgt;
  assign grp_index_o          = slot_grp.idx;
  assign grp_layer_o          = slot_grp.layer;
  assign err_o[ERR_OVF]       = slot_ovf;
  assign err_o[ERR_PROTO]     = proto_q;

endmodule

// File: doc/mlp_load_rx.md
# mlp_load_rx

Receive end of the accelerator load stream. Takes the 32-bit load beats driven into the MLP accelerator (input-row beats and weight-column beats), unpacks each two-lane beat into 16×16-bit vectors, and presents one complete group (one input row plus the matching weight column) per valid/ready handshake to the compute array. It sits directly behind the top-level load ports of `MLP_acc_top` and has no backpressure toward the host.

## Interface
Parameters:
- `LANES`, 16, 16-bit lanes per vector.
- `DW`, 16, lane width in bits.

Ports:
- `clk`  in  1  the single clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `load_en_i`  in  1  beat qualifier; a beat is sampled on each posedge where it is high.
- `load_payload_i`  in  32  `{lane 2b+1, lane 2b}`.
- `load_type_i`  in  1  1 = input beat, 0 = weight beat.
- `input_load_number`  in  4  row index (0-15), captured at the first beat of a group.
- `layer_number`  in  3  layer (0-7), captured at the first beat of a group.
- `weight_number`  in  3  weight beat slot (0-7); lanes `2w` and `2w+1`.
- `grp_valid_o`  out  1  output group is valid.
- `grp_ready_i`  in  1  consumer accepts the group.
- `grp_input_o`  out  256  input lanes; lane k occupies `[16k+15:16k]`.
- `grp_weight_o`  out  256  weight lanes, same packing.
- `grp_index_o`  out  4  captured `input_load_number`.
- `grp_layer_o`  out  3  captured `layer_number`.
- `err_o`  out  2  sticky status: [0] overflow, [1] protocol error (only with the macro).

## Operation
- The FSM has two states:
  - `S_IN` (reset state): accepts only type-1 beats. Beat `in_cnt` (0-7) writes lanes `2·in_cnt` and `2·in_cnt+1` of the assembly input vector. The first beat captures the index and layer. After the 8th beat the FSM goes to `S_W`, with `in_cnt` cleared.
  - `S_W`: accepts only type-0 beats. Each beat writes lanes `2·weight_number` and `2·weight_number+1` of the assembly weight vector, and `w_cnt` increments. On the 8th beat the group is complete; the FSM returns to `S_IN` with `w_cnt` cleared.
- Beats of the wrong type for the current state are ignored and do not advance any counter.
- When `load_en_i` is low, state and counters hold. Gaps between beats are allowed.
- Group completion, with the slot free (`!grp_valid_o`, or `grp_valid_o && grp_ready_i` in the same cycle): the assembly vectors, index and layer are copied into the output slot and `grp_valid_o` is set.
- Group completion while the slot is occupied and not being consumed (overflow): the completed group is dropped, the slot keeps its contents, and `err_o[0]` is set.
- Slot output values are stable while `grp_valid_o && !grp_ready_i`.
- The assembly vectors are not cleared between groups. A new group overwrites all lanes.

## Timing
- Reset values: `grp_valid_o`=0, `grp_input_o`=0, `grp_weight_o`=0, `grp_index_o`=0, `grp_layer_o`=0, `err_o`=0. The FSM resets to `S_IN` with counters at 0.
- Latency: `grp_valid_o` rises in the cycle after the posedge that samples the 16th beat.
- Handshake: a transfer happens on a posedge where `grp_valid_o && grp_ready_i`. `grp_valid_o` falls in the next cycle unless a completion refills the slot on that same edge, in which case it stays high with the new data.
- Back-to-back groups with `grp_ready_i` tied high lose nothing. Minimum period is 16 cycles per group.
- Reset asserted mid-group: the partial group is discarded and the next beat is treated as beat 0 of `S_IN`.
- `err_o` bits are cleared only by reset.

## Configuration
- `MLP_LOAD_RX_CHECK_EN` defined enables protocol checks. Any of the following sets `err_o[1]`:
  - a wrong-type beat;
  - `weight_number` ≠ `w_cnt`;
  - `input_load_number` or `layer_number` changing within a group.
- On such an error the group in assembly is aborted and the FSM returns to `S_IN` with counters cleared.
- `MLP_LOAD_RX_CHECK_EN` undefined: no checks. `err_o[1]` is tied to 0, wrong-type beats are silently ignored, and `weight_number` selects lanes unconditionally.

## Structure
- Shared package `mlp_pkg` holds:
  - `LANES`, `DW`, `BEATS_PER_VEC`=8;
  - `typedef logic [LANES-1:0][DW-1:0] mlp_vec_t`;
  - the FSM state enum `{S_IN, S_W}`;
  - the `err_o` bit-position constants.
- One sub-module, `mlp_grp_slot`: the output slot register. It owns valid, load-when-free and hold-under-stall, and reports overflow to the parent.

## Test plan
- **Single group, ready high.** Row 0 with lane k = k, weights all 1, layer 0 → 1 cycle after beat 16, `grp_valid_o`=1; `grp_input_o` lanes = 0..15, `grp_weight_o` lanes = 1, `grp_index_o`=0, `grp_layer_o`=0.
- **16 back-to-back rows.** Row r with lane k = r+k, ready high → 16 groups with index 0..15; group r lane 15 = r+15; `err_o`=0.
- **Stall and overflow.** Ready low across two completed groups → the slot holds group 0 and `err_o[0]`=1. Raise ready → group 0 transfers and `grp_valid_o` falls.
- **Gaps and wrong-type beats.** `load_en_i` toggling every other cycle, plus one type-0 beat injected during `S_IN` → the group completes after 16 qualifying beats with correct lanes; without the macro `err_o`=0.
- **Checks enabled.** Weight beats sent with `weight_number` order 0,1,3 → `err_o[1]`=1, the group is aborted, and the next clean group is delivered correctly.
- **Reset mid-group.** Assert `rst_n`=0 after 5 input beats → outputs return to reset values; a fresh 16-beat group is delivered normally.
